pad_reader: RTL and testbench

//  Serial gamepad front end: polls an NES-style shift-register pad and produces
//  per-frame action levels. Outputs are right/left/jump/squat/defend, the command

---
 rtl/pad_reader.sv | 161 ++++++++++++++++
 tb/tb_pad_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_reader.sv
// NES-style serial gamepad poller: latches the pad, shifts out 8 buttons and
// decodes per-frame action levels. Define PAD_DEBOUNCE_EN to require two identical frames.
module pad_reader #(
  parameter int LATCH_CYC = 4,
  parameter int HALF_CYC  = 4,
  parameter int POLL_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] raw_btn,
  output logic       right,
  output logic       left,
  output logic       jump,
  output logic       squat,
  output logic       defend,
  output logic       frame_vld
);

  localparam int MAX_AB  = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int MAX_CYC = (MAX_AB > POLL_CYC) ? MAX_AB : POLL_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    UPDATE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [7:0]       shift_reg;
  logic [1:0]       sync_reg;
  logic             sync_data;
  logic [4:0]       act_next;
  logic             load_en;

  // pad_data is asynchronous; reset to the released (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], pad_data};
  end
  assign sync_data = sync_reg[1];

  // shift_reg bits: 7 Right, 6 Left, 5 Down, 4 Up, 3 Start, 2 Select, 1 B, 0 A
  always_comb begin
    act_next    = '0;
    act_next[4] = shift_reg[7] & ~shift_reg[6];
    act_next[3] = shift_reg[6] & ~shift_reg[7];
    act_next[2] = (shift_reg[4] | shift_reg[0]) & ~shift_reg[5];
    act_next[1] = shift_reg[5] & ~(shift_reg[4] | shift_reg[0]);
    act_next[0] = shift_reg[1];
  end

`ifdef PAD_DEBOUNCE_EN
  logic [7:0] cand_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cand_reg <= '0;
    else if (state_reg == UPDATE) cand_reg <= shift_reg;
  end
  assign load_en = (shift_reg == cand_reg);
`else
  assign load_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      raw_btn   <= '0;
      right     <= 1'b0;
      left      <= 1'b0;
      jump      <= 1'b0;
      squat     <= 1'b0;
      defend    <= 1'b0;
      frame_vld <= 1'b0;
    end else begin
      frame_vld <= 1'b0;
      case (state_reg)
        IDLE: begin
          idx_reg   <= '0;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b0;
          if (cnt_reg == POLL_LAST) begin
            cnt_reg   <= '0;
            state_reg <= LATCH;
            pad_latch <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LATCH: begin
          if (cnt_reg == LATCH_LAST) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= LOW;
            pad_latch <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LOW: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= ~sync_data;
            if (idx_reg == 3'd7) begin
              state_reg <= UPDATE;
            end else begin
              state_reg <= HIGH;
              pad_clk   <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HIGH: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= LOW;
            pad_clk   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        UPDATE: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
          if (load_en) begin
            raw_btn   <= shift_reg;
            right     <= act_next[4];
            left      <= act_next[3];
            jump      <= act_next[2];
            squat     <= act_next[1];
            defend    <= act_next[0];
            frame_vld <= 1'b1;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_reader.sv
// Directed bench for pad_reader: behavioural pad model plus a scoreboard of
// expected frames popped on each frame_vld.
module tb_pad_reader;

  localparam int LATCH_CYC = 4;
  localparam int HALF_CYC  = 4;
  localparam int POLL_CYC  = 16;
  localparam int FRAME     = POLL_CYC + LATCH_CYC + 15 * HALF_CYC + 1;
`ifdef PAD_DEBOUNCE_EN
  localparam int STEP_FRAMES = 2;
`else
  localparam int STEP_FRAMES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] raw_btn;
  logic       right, left, jump, squat, defend, frame_vld;
  logic [4:0] act_obs;

  logic [7:0] btn = 8'h00;
  logic       connected = 1'b1;
  logic [7:0] pad_sr = 8'hFF;
  logic       pad_clk_d = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_vld = 0;

  typedef struct packed {
    logic [7:0] raw;
    logic [4:0] act;
  } exp_t;
  exp_t sb[$];

  pad_reader #(
    .LATCH_CYC(LATCH_CYC),
    .HALF_CYC (HALF_CYC),
    .POLL_CYC (POLL_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .raw_btn  (raw_btn),
    .right    (right),
    .left     (left),
    .jump     (jump),
    .squat    (squat),
    .defend   (defend),
    .frame_vld(frame_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign act_obs  = {right, left, jump, squat, defend};
  assign pad_data = connected ? pad_sr[0] : 1'b1;

  // Pad: parallel-loads active-low buttons while latched, shifts on pad_clk rise
  always @(posedge clk) begin
    pad_clk_d <= pad_clk;
    if (pad_latch)                 pad_sr <= ~btn;
    else if (pad_clk && !pad_clk_d) pad_sr <= {1'b1, pad_sr[7:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_vld(input string tag, input int gap, output logic [4:0] act_or);
    bit   seen;
    int   n;
    exp_t e;
    seen   = 1'b0;
    n      = 0;
    act_or = '0;
    while (!seen && n < gap + 20) begin
      @(negedge clk);
      n++;
      if (frame_vld) seen = 1'b1;
      else           act_or = act_or | act_obs;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      last_vld = cyc;
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk({tag, "_gap"}, cyc - last_vld, gap);
      last_vld = cyc;
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_raw"}, raw_btn, e.raw);
        chk({tag, "_act"}, act_obs, e.act);
      end
      @(negedge clk);
      chk({tag, "_pulse"}, frame_vld, 1'b0);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] b, input logic conn,
                      input logic [7:0] raw, input logic [4:0] act);
    exp_t       e;
    logic [4:0] dummy;
    btn       = b;
    connected = conn;
    e.raw     = raw;
    e.act     = act;
    sb.push_back(e);
    expect_vld(tag, STEP_FRAMES * FRAME, dummy);
    $display("step %s btn=%h raw=%h act=%b", tag, b, raw_btn, act_obs);
  endtask

  task automatic wait_latch_pulse(input string tag);
    int n;
    n = 0;
    while (!pad_latch && n < FRAME + 10) begin @(negedge clk); n++; end
    while (pad_latch && n < FRAME + 10) begin @(negedge clk); n++; end
    if (n >= FRAME + 10) chk({tag, "_latch_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int         first_latch, latch_hi, clk_hi, clk_rise, rises;
    logic       prev;
    exp_t       e;
    logic [4:0] act_or;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_raw", raw_btn, 8'h00);
    chk("rst_act", act_obs, 5'b00000);
    chk("rst_vld", frame_vld, 1'b0);
    chk("rst_latch", pad_latch, 1'b0);
    chk("rst_padclk", pad_clk, 1'b0);
    $display("reset outputs raw=%h act=%b", raw_btn, act_obs);

    // First frame timing with idle pad
    rst = 1'b0;
    last_vld = cyc;
    e.raw = 8'h00;
    e.act = 5'b00000;
    sb.push_back(e);
    first_latch = -1;
    latch_hi = 0;
    clk_hi = 0;
    clk_rise = 0;
    prev = 1'b0;
    for (int n = 1; n < FRAME; n++) begin
      @(negedge clk);
      if (pad_latch && first_latch < 0) first_latch = n;
      if (pad_latch) latch_hi++;
      if (pad_clk) clk_hi++;
      if (pad_clk && !prev) clk_rise++;
      prev = pad_clk;
    end
    chk("first_latch_cyc", first_latch, POLL_CYC);
    chk("latch_width", latch_hi, LATCH_CYC);
    chk("padclk_high_cyc", clk_hi, 7 * HALF_CYC);
    chk("padclk_rises", clk_rise, 7);
    $display("frame timing latch@%0d width=%0d clk_hi=%0d rises=%0d",
             first_latch, latch_hi, clk_hi, clk_rise);
    expect_vld("idle_frame", FRAME, act_or);

    //   tag            btn    conn  raw    {R,L,J,S,D}
    step("right",       8'h80, 1'b1, 8'h80, 5'b10000);
    step("up_b",        8'h12, 1'b1, 8'h12, 5'b00101);
    step("left_right",  8'hC0, 1'b1, 8'hC0, 5'b00000);
    step("down_a",      8'h21, 1'b1, 8'h21, 5'b00000);
    step("r_l_dn_a",    8'hE1, 1'b1, 8'hE1, 5'b00000);
    step("down",        8'h20, 1'b1, 8'h20, 5'b00010);
    step("left",        8'h40, 1'b1, 8'h40, 5'b01000);
    step("up_down",     8'h30, 1'b1, 8'h30, 5'b00000);
    step("start_sel",   8'h0C, 1'b1, 8'h0C, 5'b00000);
    step("unplugged",   8'hFF, 1'b0, 8'h00, 5'b00000);
    step("r_up_b_a",    8'h93, 1'b1, 8'h93, 5'b10101);

    // Reset during the HIGH phase of bit 3
    rises = 0;
    prev = 1'b0;
    for (int n = 0; n < FRAME && rises < 4; n++) begin
      @(negedge clk);
      if (pad_clk && !prev) rises++;
      prev = pad_clk;
    end
    chk("mid_rises", rises, 4);
    chk("mid_padclk_high", pad_clk, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_padclk", pad_clk, 1'b0);
    chk("mid_rst_latch", pad_latch, 1'b0);
    chk("mid_rst_raw", raw_btn, 8'h00);
    chk("mid_rst_act", act_obs, 5'b00000);
    chk("mid_rst_vld", frame_vld, 1'b0);
    $display("mid-frame reset padclk=%b raw=%h act=%b", pad_clk, raw_btn, act_obs);
    btn = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    last_vld = cyc;
    e.raw = 8'h00;
    e.act = 5'b00000;
    sb.push_back(e);
    first_latch = -1;
    for (int n = 1; n < FRAME && first_latch < 0; n++) begin
      @(negedge clk);
      if (pad_latch) first_latch = n;
    end
    chk("post_rst_latch_cyc", first_latch, POLL_CYC);
    expect_vld("post_rst_frame", FRAME, act_or);

    // Right held for exactly one frame
    btn = 8'h80;
    wait_latch_pulse("glitch");
    btn = 8'h00;
`ifdef PAD_DEBOUNCE_EN
    e.raw = 8'h00;
    e.act = 5'b00000;
    sb.push_back(e);
    expect_vld("glitch_filtered", 3 * FRAME, act_or);
    chk("glitch_right_never", act_or[4], 1'b0);
`else
    e.raw = 8'h80;
    e.act = 5'b10000;
    sb.push_back(e);
    expect_vld("glitch_frame", FRAME, act_or);
    e.raw = 8'h00;
    e.act = 5'b00000;
    sb.push_back(e);
    expect_vld("glitch_release", FRAME, act_or);
`endif
    $display("one-frame right: raw=%h act=%b", raw_btn, act_obs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
